serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Multi-cycle bit-serial subtractor: computes A - B one bit per clock, LSB first,
//  with a single registered full-subtractor cell and a borrow flip-flop.
//  Inverse arithmetic partner of the ripple full-adder datapath. Used where area
//  matters more than latency (ALU slow path, address compare).
//  Start/done handshake; result and flags hold until the next accepted start.
// PARAMETERS
//  WIDTH  16  operand/result width in bits (>=2)
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      asynchronous reset, active low
//  start       in   1      request; sampled only in IDLE
//  a           in   WIDTH  minuend; captured on the accepting edge
//  b           in   WIDTH  subtrahend; captured on the accepting edge
//  busy        out  1      high while in RUN
//  done        out  1      one-cycle pulse: result valid
//  diff        out  WIDTH  A - B (mod 2^WIDTH, or saturated, see CONFIGURATION)
//  borrow_out  out  1      1 when A < B (unsigned)
//  zero        out  1      1 when the final diff == 0
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE; busy, done, diff, borrow_out, zero,
//    the bit counter, the borrow FF and the operand shift registers all 0.
//    Reset mid-RUN aborts; no done pulse is produced.
//  - FSM: IDLE -(start)-> RUN -(WIDTH bits done)-> DONE -> IDLE (unconditional).
//  - Accept: at the edge where state==IDLE && start==1:
//    a_sr<=a; b_sr<=b; borrow<=0; cnt<=0; state<=RUN.
//  - RUN, each edge: with d = a_sr[0]^b_sr[0]^borrow and
//    bo = (~a_sr[0]&b_sr[0]) | (~(a_sr[0]^b_sr[0])&borrow):
//    a_sr, b_sr shift right; d enters the result shift register at the MSB;
//    borrow<=bo; cnt<=cnt+1. On the edge where cnt==WIDTH-1: state<=DONE.
//  - DONE cycle: done=1. diff, borrow_out and zero are registered and valid
//    from this cycle. They hold until the next accepting edge, then clear to 0.
//  - Latency: start accepted at edge E0 -> done high in the cycle after edge
//    E0+WIDTH. Throughput: one operation per WIDTH+2 cycles.
//  - start while RUN or DONE: ignored, not queued. a/b changes after
//    acceptance: no effect.
//  - cnt is $clog2(WIDTH) bits wide. It never wraps in RUN, because RUN exits
//    at WIDTH-1.
// CONFIGURATION
//  SERIAL_SUB_SAT_EN defined: unsigned saturating subtract. If the final
//    borrow==1, diff is forced to 0 (zero=1, borrow_out=1 still reported).
//  Not defined: two's-complement wrap; diff = (A - B) mod 2^WIDTH.
// TESTING (WIDTH=16)
//  1. a=0x0005, b=0x0003, start for 1 cycle -> busy for 16 cycles; done in the
//     17th cycle after the accepting edge; diff=0x0002, borrow_out=0, zero=0.
//  2. a=0x0003, b=0x0005 -> diff=0xFFFE, borrow_out=1, zero=0;
//     with SERIAL_SUB_SAT_EN: diff=0x0000, borrow_out=1, zero=1.
//  3. a=0x1234, b=0x1234 -> diff=0x0000, borrow_out=0, zero=1;
//     a=0x0000, b=0xFFFF -> diff=0x0001, borrow_out=1.
//  4. Accept a=0x8000, b=0x0001; pulse start with a=0, b=0 in RUN cycle 5 ->
//     ignored; diff=0x7FFF. Exactly one done pulse. Result holds 10 idle cycles.
//  5. rst_n low in RUN cycle 8 -> all outputs 0 immediately; no done pulse.
//     Restart with 0x00FF-0x000F -> diff=0x00F0.
//  6. Back-to-back: start held high continuously -> accepted every 18 cycles.
//     Each done pulse is 1 cycle wide.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: A - B one bit per clock, LSB first, through one full-subtractor cell.
// Define SERIAL_SUB_SAT_EN for unsigned saturation (diff forced to 0 on final borrow).
//
// state  | meaning
// IDLE   | waiting for start; result outputs hold last value
// RUN    | shifting operands through the subtractor cell, WIDTH cycles
// DONE   | one-cycle done pulse, result valid
module serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res_sr;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_last;
  logic             w_d;
  logic             w_bo;
  logic [WIDTH-1:0] w_res_next;
  logic [WIDTH-1:0] w_diff_final;

  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_last     = (r_state == S_RUN) && (r_cnt == CW'(WIDTH-1));
  assign w_d        = r_a_sr[0] ^ r_b_sr[0] ^ r_borrow;
  assign w_bo       = (~r_a_sr[0] & r_b_sr[0]) | (~(r_a_sr[0] ^ r_b_sr[0]) & r_borrow);
  assign w_res_next = {w_d, r_res_sr[WIDTH-1:1]};

`ifdef SERIAL_SUB_SAT_EN
  assign w_diff_final = w_bo ? '0 : w_res_next;
`else
  assign w_diff_final = w_res_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_RUN);
    done = (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr     <= '0;
      r_b_sr     <= '0;
      r_res_sr   <= '0;
      r_borrow   <= 1'b0;
      r_cnt      <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      zero       <= 1'b0;
    end else if (w_accept) begin
      r_a_sr     <= a;
      r_b_sr     <= b;
      r_res_sr   <= '0;
      r_borrow   <= 1'b0;
      r_cnt      <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      zero       <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
      r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
      r_res_sr <= w_res_next;
      r_borrow <= w_bo;
      r_cnt    <= r_cnt + 1'b1;
      // final bit: publish the completed result alongside the DONE transition
      if (w_last) begin
        diff       <= w_diff_final;
        borrow_out <= w_bo;
        zero       <= (w_diff_final == '0);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=16); expectations follow SERIAL_SUB_SAT_EN when defined.
module tb_serial_subtractor;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         zero;

  int n_checks = 0;
  int n_errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full operation: start for one cycle, wait for done, verify latency and result.
  task automatic run_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [W-1:0] ediff, input logic eb, input logic ez);
    int k;
    int busy_n;
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; a = '1; b = '0;
    k = 0; busy_n = 0;
    do begin
      @(negedge clk);
      k++;
      if (busy) busy_n++;
    end while (!done && k < 40);
    check({tag, "_lat"}, k, 17);
    check({tag, "_busy"}, busy_n, 16);
    check({tag, "_diff"}, diff, ediff);
    check({tag, "_bo"}, borrow_out, eb);
    check({tag, "_zero"}, zero, ez);
    @(negedge clk);
    check({tag, "_done_w"}, done, 0);
    check({tag, "_hold"}, diff, ediff);
  endtask

  initial begin
    int pulses;
    int t_prev;
    logic [W-1:0] seen;
    logic prev_done;

    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_flags", {borrow_out, zero}, 0);
    @(negedge clk) rst_n = 1'b1;

    run_op("t1", 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0);
`ifdef SERIAL_SUB_SAT_EN
    run_op("t2", 16'h0003, 16'h0005, 16'h0000, 1'b1, 1'b1);
    run_op("t3b", 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 1'b1);
`else
    run_op("t2", 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0);
    run_op("t3b", 16'h0000, 16'hFFFF, 16'h0001, 1'b1, 1'b0);
`endif
    run_op("t3a", 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1);

    // start pulse during RUN must be ignored
    @(negedge clk);
    a = 16'h8000; b = 16'h0001; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 start = 1'b1; a = '0; b = '0;
    @(posedge clk);
    #1 start = 1'b0;
    pulses = 0; seen = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin pulses++; seen = diff; end
    end
    check("t4_pulses", pulses, 1);
    check("t4_diff", seen, 16'h7FFF);
    check("t4_hold", diff, 16'h7FFF);
    check("t4_flags", {borrow_out, zero}, 0);

    // async reset mid-RUN
    @(negedge clk);
    a = 16'h1234; b = 16'h0001; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("t5_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t5_busy", busy, 0);
    check("t5_outs", {done, borrow_out, zero, diff}, 0);
    @(negedge clk) rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("t5_no_done", pulses, 0);
    run_op("t5r", 16'h00FF, 16'h000F, 16'h00F0, 1'b0, 1'b0);

    // start held high: one op every 18 cycles, 1-cycle done pulses
    @(negedge clk);
    a = 16'h0005; b = 16'h0003; start = 1'b1;
    pulses = 0; t_prev = 0; prev_done = 1'b0;
    for (int t = 1; t <= 60; t++) begin
      @(negedge clk);
      if (done) begin
        if (prev_done) check("t6_width", 2, 1);
        if (pulses == 0) check("t6_first", t, 17);
        else             check("t6_period", t - t_prev, 18);
        check("t6_diff", diff, 16'h0002);
        pulses++;
        t_prev = t;
      end
      prev_done = done;
    end
    check("t6_pulses", pulses, 3);
    start = 1'b0;
    repeat (25) @(negedge clk);
    check("t6_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
